// File: rtl/fbuf_scanout.sv
// 640x480-style raster scanout: walks the framebuffer BRAM in raster order, expands RGB332
// to RGB888 and emits sync/de/pixel aligned 3 clocks behind the raster counters.
module fbuf_scanout #(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int SCALE_SHIFT         = 0,
  parameter int FBUF_ADDR_WIDTH     = 19,
  parameter int FBUF_DATA_WIDTH     = 8,
  parameter int H_ACTIVE            = 640,
  parameter int H_FP                = 16,
  parameter int H_SYNC              = 96,
  parameter int H_BP                = 48,
  parameter int V_ACTIVE            = 480,
  parameter int V_FP                = 10,
  parameter int V_SYNC              = 2,
  parameter int V_BP                = 33,
  parameter bit SYNC_POL            = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fbuf_rst_busy,
  output logic                       fbuf_rd_en,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_rd_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rd_data,
  output logic                       vid_hsync,
  output logic                       vid_vsync,
  output logic                       vid_de,
  output logic [23:0]                vid_rgb,
  output logic                       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam int AW      = FBUF_ADDR_WIDTH;
  localparam int V_FB    = FRAME_HEIGHT_SCALED << SCALE_SHIFT;
  localparam int V_LINES = (V_FB < V_ACTIVE) ? V_FB : V_ACTIVE;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS      = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE      = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS      = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE      = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_FB_END  = VW'(V_LINES);
  localparam logic [SW-1:0] SUB_LAST  = SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [AW-1:0] LINE_STEP = AW'(FRAME_WIDTH_SCALED);

  // Stage 0: raster counters and running address
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [AW-1:0] r_line_base;
  logic [AW-1:0] r_x_addr;
  logic [SW-1:0] r_x_sub;
  logic [SW-1:0] r_y_sub;

  logic w_h_wrap, w_v_wrap, w_active, w_hs, w_vs, w_fs, w_rd_ok;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs     = ((r_h_cnt >= H_SS) && (r_h_cnt < H_SE)) ? SYNC_POL : ~SYNC_POL;
  assign w_vs     = ((r_v_cnt >= V_SS) && (r_v_cnt < V_SE)) ? SYNC_POL : ~SYNC_POL;
  assign w_fs     = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_rd_ok  = w_active && !fbuf_rst_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_line_base <= '0;
      r_x_addr    <= '0;
      r_x_sub     <= '0;
      r_y_sub     <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end

      // x_addr steps once per replicated pixel group; cleared at each line end
      if (w_h_wrap) begin
        r_x_addr <= '0;
        r_x_sub  <= '0;
      end else if (w_active) begin
        if (r_x_sub == SUB_LAST) begin
          r_x_sub  <= '0;
          r_x_addr <= r_x_addr + 1'b1;
        end else begin
          r_x_sub <= r_x_sub + 1'b1;
        end
      end

      // line_base advances after every replicated line group inside the framebuffer
      if (w_h_wrap) begin
        if (w_v_wrap) begin
          r_line_base <= '0;
          r_y_sub     <= '0;
        end else if (r_v_cnt < V_FB_END) begin
          if (r_y_sub == SUB_LAST) begin
            r_y_sub     <= '0;
            r_line_base <= r_line_base + LINE_STEP;
          end else begin
            r_y_sub <= r_y_sub + 1'b1;
          end
        end
      end
    end
  end

  // Stage 1: BRAM request plus delayed timing; r_rd_en doubles as the pixel-valid bit
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_de1, r_hs1, r_vs1, r_fs1;
  // Stage 2: BRAM data arrives; timing and valid follow
  logic          r_de2, r_hs2, r_vs2, r_fs2, r_ok2;
  // Stage 3: registered video outputs
  logic          r_de3, r_hs3, r_vs3, r_fs3;
  logic [23:0]   r_rgb3;

  logic [23:0]   w_rgb;
  logic [7:0]    w_d;

  always_comb begin
    w_d   = fbuf_rd_data[7:0];
    w_rgb = '0;
    if (r_ok2) begin
      w_rgb = {w_d[7:5], w_d[7:5], w_d[7:6],
               w_d[4:2], w_d[4:2], w_d[4:3],
               w_d[1:0], w_d[1:0], w_d[1:0], w_d[1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_de1     <= 1'b0;
      r_hs1     <= ~SYNC_POL;
      r_vs1     <= ~SYNC_POL;
      r_fs1     <= 1'b0;
      r_de2     <= 1'b0;
      r_hs2     <= ~SYNC_POL;
      r_vs2     <= ~SYNC_POL;
      r_fs2     <= 1'b0;
      r_ok2     <= 1'b0;
      r_de3     <= 1'b0;
      r_hs3     <= ~SYNC_POL;
      r_vs3     <= ~SYNC_POL;
      r_fs3     <= 1'b0;
      r_rgb3    <= '0;
    end else begin
      r_rd_en <= w_rd_ok;
      if (w_active) begin
        r_rd_addr <= r_line_base + r_x_addr;
      end
      r_de1  <= w_active;
      r_hs1  <= w_hs;
      r_vs1  <= w_vs;
      r_fs1  <= w_fs;

      r_de2  <= r_de1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_fs2  <= r_fs1;
      r_ok2  <= r_rd_en;

      r_de3  <= r_de2;
      r_hs3  <= r_hs2;
      r_vs3  <= r_vs2;
      r_fs3  <= r_fs2;
      r_rgb3 <= w_rgb;
    end
  end

  assign fbuf_rd_en   = r_rd_en;
  assign fbuf_rd_addr = r_rd_addr;
  assign vid_hsync    = r_hs3;
  assign vid_vsync    = r_vs3;
  assign vid_de       = r_de3;
  assign vid_rgb      = r_rgb3;
  assign frame_start  = r_fs3;

endmodule

// File: tb/tb_fbuf_scanout.sv
// Directed bench for fbuf_scanout: a default-timing instance (reset, line timing, colour, busy),
// a tiny-timing instance (vsync, frame period, last address) and a 2x scaled instance (addresses).
module tb_fbuf_scanout;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: defaults ----------------
  logic        a_busy;
  logic        a_rd_en;
  logic [18:0] a_rd_addr;
  logic [7:0]  a_rd_data;
  logic        a_hs, a_vs, a_de, a_fs;
  logic [23:0] a_rgb;
  logic [7:0]  mem [0:1023];

  fbuf_scanout u_a (
    .clk(clk), .rst_n(rst_n), .fbuf_rst_busy(a_busy),
    .fbuf_rd_en(a_rd_en), .fbuf_rd_addr(a_rd_addr), .fbuf_rd_data(a_rd_data),
    .vid_hsync(a_hs), .vid_vsync(a_vs), .vid_de(a_de), .vid_rgb(a_rgb),
    .frame_start(a_fs)
  );

  always @(posedge clk) if (a_rd_en) a_rd_data <= mem[a_rd_addr[9:0]];

  // ---------------- instance B: tiny raster (14 x 10 = 140 clocks/frame) ----------------
  logic        b_busy = 1'b0;
  logic        b_rd_en;
  logic [7:0]  b_rd_addr;
  logic [7:0]  b_rd_data;
  logic        b_hs, b_vs, b_de, b_fs;
  logic [23:0] b_rgb;

  fbuf_scanout #(
    .FRAME_WIDTH_SCALED(8), .FRAME_HEIGHT_SCALED(6), .SCALE_SHIFT(0), .FBUF_ADDR_WIDTH(8),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .fbuf_rst_busy(b_busy),
    .fbuf_rd_en(b_rd_en), .fbuf_rd_addr(b_rd_addr), .fbuf_rd_data(b_rd_data),
    .vid_hsync(b_hs), .vid_vsync(b_vs), .vid_de(b_de), .vid_rgb(b_rgb),
    .frame_start(b_fs)
  );

  always @(posedge clk) if (b_rd_en) b_rd_data <= b_rd_addr;

  // ---------------- instance C: 2x scaled 320x240 ----------------
  logic        c_busy = 1'b0;
  logic        c_rd_en;
  logic [16:0] c_rd_addr;
  logic [7:0]  c_rd_data;
  logic        c_hs, c_vs, c_de, c_fs;
  logic [23:0] c_rgb;

  fbuf_scanout #(
    .FRAME_WIDTH_SCALED(320), .FRAME_HEIGHT_SCALED(240), .SCALE_SHIFT(1), .FBUF_ADDR_WIDTH(17)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .fbuf_rst_busy(c_busy),
    .fbuf_rd_en(c_rd_en), .fbuf_rd_addr(c_rd_addr), .fbuf_rd_data(c_rd_data),
    .vid_hsync(c_hs), .vid_vsync(c_vs), .vid_de(c_de), .vid_rgb(c_rgb),
    .frame_start(c_fs)
  );

  always @(posedge clk) if (c_rd_en) c_rd_data <= c_rd_addr[7:0];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_hsync"}, a_hs, 1);
    check({tag, "_vsync"}, a_vs, 1);
    check({tag, "_de"}, a_de, 0);
    check({tag, "_rgb"}, a_rgb, 0);
    check({tag, "_rd_en"}, a_rd_en, 0);
    check({tag, "_rd_addr"}, a_rd_addr, 0);
    check({tag, "_fs"}, a_fs, 0);
  endtask

  // ---------------- main sequence ----------------
  int p, q;
  int a_de_cnt, a_hs_cnt, a_hs_first;
  int b_vs_cnt, b_vs_first, b_last_fs, b_fs_cnt;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
    mem[100] = 8'b11100011;
    mem[101] = 8'b11111100;
    mem[102] = 8'h00;

    // C address expectations in issue order, keyed by read-request position
    exp_q = {32'd0, 32'd0, 32'd1, 32'd319, 32'd0, 32'd319, 32'd320, 32'd321};

    a_de_cnt = 0; a_hs_cnt = 0; a_hs_first = -1;
    b_vs_cnt = 0; b_vs_first = -1; b_last_fs = -1; b_fs_cnt = 0;

    a_busy = 1'b1;
    rst_n  = 1'b0;
    repeat (10) step();
    check_a_reset("rst");
    check("rst_b_hsync", b_hs, 1);

    rst_n = 1'b1;
    cyc   = 0;
    while (cyc < 1613) begin
      step();
      p = cyc - 3;
      q = cyc - 1;

      // A: read port, busy window covers positions 0..99
      if (q == 0)   check("a_rd_en_busy_first", a_rd_en, 0);
      if (q == 99)  check("a_rd_en_busy_last", a_rd_en, 0);
      if (q == 100) begin
        check("a_rd_en_after_busy", a_rd_en, 1);
        check("a_rd_addr_100", a_rd_addr, 100);
      end
      if (q == 639) check("a_rd_addr_639", a_rd_addr, 639);
      if (q == 700) begin
        check("a_rd_en_blank", a_rd_en, 0);
        check("a_rd_addr_hold", a_rd_addr, 639);
      end
      if (q == 800) check("a_rd_addr_line1", a_rd_addr, 640);
      if (cyc == 100) a_busy = 1'b0;

      // A: video outputs
      if (p == 0) begin
        check("a_fs_first", a_fs, 1);
        check("a_de_first", a_de, 1);
        check("a_rgb_busy_first", a_rgb, 0);
      end
      if (p == 1) check("a_fs_pulse", a_fs, 0);
      if (p == 99) begin
        check("a_de_busy", a_de, 1);
        check("a_rgb_busy_last", a_rgb, 0);
      end
      if (p == 100) check("a_rgb_magenta", a_rgb, 24'hFF00FF);
      if (p == 101) check("a_rgb_yellow", a_rgb, 24'hFFFF00);
      if (p == 102) check("a_rgb_black", a_rgb, 24'h000000);
      if (p == 103) check("a_rgb_a5", a_rgb, 24'hB62455);
      if (p == 640) check("a_rgb_blank", a_rgb, 0);
      if (p >= 0 && p < 800) begin
        if (a_de) a_de_cnt++;
        if (!a_hs) begin
          a_hs_cnt++;
          if (a_hs_first < 0) a_hs_first = p;
        end
      end
      if (p == 800) begin
        check("a_de_clocks", a_de_cnt, 640);
        check("a_hsync_clocks", a_hs_cnt, 96);
        check("a_hsync_start", a_hs_first, 656);
        check("a_de_next_line", a_de, 1);
        check("a_vsync_idle", a_vs, 1);
      end
      if (p == 1610) begin
        check("a_de_prereset", a_de, 1);
        check("a_rgb_prereset", a_rgb, 24'hB62455);
      end

      // B: small raster frame timing
      if (p == 9)  check("b_hsync_before", b_hs, 1);
      if (p == 10) check("b_hsync_start", b_hs, 0);
      if (p == 12) check("b_hsync_end", b_hs, 0);
      if (p == 13) check("b_hsync_after", b_hs, 1);
      if (p >= 0 && p < 140 && !b_vs) begin
        b_vs_cnt++;
        if (b_vs_first < 0) b_vs_first = p;
      end
      if (p == 140) begin
        check("b_vsync_clocks", b_vs_cnt, 28);
        check("b_vsync_start", b_vs_first, 98);
      end
      if (p >= 0 && b_fs) begin
        if (b_last_fs >= 0) check("b_frame_period", p - b_last_fs, 140);
        b_last_fs = p;
        b_fs_cnt++;
      end
      if (q == 77)  check("b_rd_addr_last", b_rd_addr, 47);
      if (q == 78)  check("b_rd_en_after_last", b_rd_en, 0);
      if (q == 140) begin
        check("b_rd_addr_wrap", b_rd_addr, 0);
        check("b_rd_en_wrap", b_rd_en, 1);
      end

      // C: replicated addresses
      if (q == 0 || q == 1 || q == 2 || q == 639 || q == 800 || q == 1439 ||
          q == 1600 || q == 1602) begin
        if (exp_q.size() > 0) check($sformatf("c_rd_addr_%0d", q), c_rd_addr, exp_q.pop_front());
      end
    end
    check("b_frame_starts", b_fs_cnt, 12);
    check("c_queue_drained", exp_q.size(), 0);

    // Mid-frame reset: outputs must return to reset values without waiting for an edge
    rst_n = 1'b0;
    #2;
    check_a_reset("midrst");
    repeat (10) step();
    check_a_reset("midrst_hold");

    rst_n = 1'b1;
    cyc   = 0;
    check("restart_rd_en_cyc0", a_rd_en, 0);
    step();
    check("restart_rd_en", a_rd_en, 1);
    check("restart_rd_addr", a_rd_addr, 0);
    step();
    check("restart_fs_early", a_fs, 0);
    step();
    check("restart_fs", a_fs, 1);
    check("restart_de", a_de, 1);
    check("restart_rgb", a_rgb, 24'hB62455);
    check("restart_b_fs", b_fs, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
